// File: rtl/ls_dma_mover.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ls_dma_mover
//  Description : Block-transfer DMA mover acting as the sole master on the
//                local store single port. Executes one command at a time:
//                GET moves quadwords from the input stream into local store,
//                PUT moves quadwords from local store onto the output stream.
//  Ports       : clk/rst              clock, synchronous active-high reset
//                cmd_*                command handshake and fields
//                in_*                 GET data stream (valid/ready)
//                out_*                PUT data stream (valid/ready, registered)
//                ls_*                 local store port (combinational read)
//                done_*               one-cycle completion pulse, tag, error
//  Options     : `define LS_DMA_BOUNDS_CHECK_EN rejects commands whose
//                quadword range runs past the top of local store (done_err=1).
//                Without it, addresses wrap modulo 2^LS_AW and done_err is 0.
//  Data words are big-endian: the most significant bit is the first byte's
//  MSB, identical to local store layout, so data passes through unmodified.
//  Revision    : 1.0  initial release
// ============================================================================
module ls_dma_mover #(
    parameter int LS_AW  = 15,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 8,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [LS_AW-1:0]  cmd_ls_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [TAG_W-1:0]  cmd_tag,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LS_AW-1:0]  ls_addr,
    output logic              ls_write_en,
    output logic [DATA_W-1:0] ls_data_in,
    input  logic [DATA_W-1:0] ls_data_out,
    output logic              done_valid,
    output logic [TAG_W-1:0]  done_tag,
    output logic              done_err
);

    localparam int c_QW_W  = LS_AW - 4;
    localparam int c_SUM_W = ((c_QW_W > LEN_W) ? c_QW_W : LEN_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GET  = 2'd1,
        S_PUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_QW_W-1:0]   r_qw;          // current quadword index
    logic [LEN_W-1:0]    r_rem;         // quadwords still to move
    logic [TAG_W-1:0]    r_tag;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_err;

    logic                w_rem_nz;
    logic                w_get_beat;
    logic                w_put_load;
    logic                w_put_drain;
    logic                w_oob;
    logic                w_unused;

    // Byte offset within a quadword is meaningless to this block.
    assign w_unused    = ^cmd_ls_addr[3:0];

    assign w_rem_nz    = |r_rem;
    assign w_get_beat  = (r_state == S_GET) && w_rem_nz && in_valid;
    // Output buffer can take a new quadword when empty or being consumed.
    assign w_put_load  = (r_state == S_PUT) && w_rem_nz && (!r_out_valid || out_ready);
    assign w_put_drain = (r_state == S_PUT) && !w_rem_nz && (!r_out_valid || out_ready);

`ifdef LS_DMA_BOUNDS_CHECK_EN
    logic [c_SUM_W-1:0] w_end_qw;
    // Widened sum so start + len cannot overflow before the compare.
    assign w_end_qw = c_SUM_W'(cmd_ls_addr[LS_AW-1:4]) + c_SUM_W'(cmd_len);
    assign w_oob    = (w_end_qw > (c_SUM_W'(1) << c_QW_W));
`else
    assign w_oob    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_qw        <= '0;
            r_rem       <= '0;
            r_tag       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_qw  <= cmd_ls_addr[LS_AW-1:4];
                        r_tag <= cmd_tag;
                        r_err <= w_oob;
                        r_rem <= w_oob ? '0 : cmd_len;
                        if (w_oob || (cmd_len == '0))
                            r_state <= S_DONE;
                        else if (cmd_dir)
                            r_state <= S_PUT;
                        else
                            r_state <= S_GET;
                    end
                end
                S_GET: begin
                    if (w_get_beat) begin
                        r_qw  <= r_qw + c_QW_W'(1);
                        r_rem <= r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1))
                            r_state <= S_DONE;
                    end
                end
                S_PUT: begin
                    if (w_put_load) begin
                        r_out_data  <= ls_data_out;
                        r_out_valid <= 1'b1;
                        r_qw        <= r_qw + c_QW_W'(1);
                        r_rem       <= r_rem - LEN_W'(1);
                    end else if (w_put_drain) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign in_ready    = (r_state == S_GET) && w_rem_nz;
    assign ls_write_en = w_get_beat;
    assign ls_data_in  = in_data;
    assign ls_addr     = {r_qw, 4'b0000};
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign done_valid  = (r_state == S_DONE);
    assign done_tag    = r_tag;
    assign done_err    = r_err;

endmodule
`default_nettype wire
